robot_fx_sequencer: RTL and testbench
=====================================

ROBOT_FX_SEQUENCER -- requirements
Module: robot_fx_sequencer

Interface
REQ-001 SHALL have parameter STEP_SAMPLES, default 48, meaning sample ticks per wet-gain step (legal 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port sample_tick  input  1  one-clock pulse per audio sample; driven by the audio stream valid.
REQ-005 SHALL have port fx_req  input  1  level; 1 requests the robot effect, 0 requests bypass.
REQ-006 SHALL have port freq_sel  input  2  carrier select: 0=300 Hz, 1=500 Hz, 2=800 Hz, 3=1200 Hz.
REQ-007 SHALL have port fx_enable  output  1  enable to the ring-modulator datapath.
REQ-008 SHALL have port phase_inc  output  32  carrier DDS increment to the datapath.
REQ-009 SHALL have port wet_gain  output  4  wet mix in eighths, range 0..8.
REQ-010 SHALL have port state  output  2  FSM state: 0=BYPASS, 1=RAMP_UP, 2=ACTIVE, 3=RAMP_DOWN.
REQ-011 SHALL have port busy  output  1  1 while state is RAMP_UP or RAMP_DOWN.

Function
REQ-012 All outputs SHALL be registered; all decisions use input values sampled at the clk edge.
REQ-013 phase_inc SHALL be floor(f*2^32/48000): sel0=26843545, sel1=44739242, sel2=71582788, sel3=107374182.
REQ-014 The block SHALL hold an active select cur_sel; phase_inc SHALL change only when cur_sel is loaded.
REQ-015 cur_sel SHALL be loaded from freq_sel only on entry to RAMP_UP from BYPASS or from RAMP_DOWN at wet_gain 0.
REQ-016 A 16-bit step counter SHALL count sample_tick in ramp states; on the tick that makes it equal STEP_SAMPLES, it clears and wet_gain steps by one.
REQ-017 On every state transition the step counter SHALL clear; a tick in the same cycle as the transition is not counted.
REQ-018 BYPASS: wet_gain=0, fx_enable=0; fx_req=1 -> load cur_sel, fx_enable=1, go RAMP_UP on the next edge.
REQ-019 RAMP_UP: wet_gain increments per REQ-016; on reaching 8 -> ACTIVE in the same edge.
REQ-020 RAMP_UP or ACTIVE: fx_req=0 or freq_sel!=cur_sel -> RAMP_DOWN starting from the current wet_gain.
REQ-021 RAMP_DOWN: wet_gain decrements per REQ-016.
REQ-022 RAMP_DOWN with fx_req=1 and freq_sel==cur_sel and wet_gain>0 -> RAMP_UP, reversing from the current gain without a reload.
REQ-023 RAMP_DOWN on reaching wet_gain 0: fx_req=1 -> load cur_sel, go RAMP_UP, fx_enable stays 1; fx_req=0 -> BYPASS, fx_enable=0 on the same edge.
REQ-024 wet_gain SHALL saturate within 0..8 and never wrap.
REQ-025 A full ramp SHALL take exactly 8*STEP_SAMPLES ticks; a retune SHALL take exactly 16*STEP_SAMPLES ticks.
REQ-026 ACTIVE with an unchanged request SHALL hold all outputs indefinitely.
REQ-027 sample_tick held high for consecutive clocks SHALL count once per clock.

Reset
REQ-028 rst=1 at an edge SHALL force: state=0, wet_gain=0, fx_enable=0, cur_sel=1, phase_inc=44739242, step counter=0, busy=0.
REQ-029 Reset SHALL take precedence over every other event, including mid-ramp, and SHALL return the block to BYPASS with no ramp-down.

Verification (bench STEP_SAMPLES=4, tick every 10 clocks unless noted)
REQ-030 Reset check: assert rst for 2 clocks -> state 0, wet_gain 0, fx_enable 0, phase_inc 44739242, busy 0.
REQ-031 Ramp up: fx_req=1, freq_sel=2 -> next edge fx_enable=1, phase_inc=71582788, state 1; wet_gain=1 after tick 4; wet_gain=8 and state 2 after tick 32; busy=0.
REQ-032 Retune: from ACTIVE at sel2, set freq_sel=3 -> state 3; gain 8->0 over 32 ticks with phase_inc=71582788 throughout; then phase_inc=107374182, state 1, gain back to 8 after 32 more ticks; fx_enable=1 throughout.
REQ-033 Abort: drop fx_req at wet_gain 5 during RAMP_UP -> state 3; wet_gain 0 after 20 ticks, then state 0 and fx_enable 0 on that edge; re-raise fx_req at gain 2 in a second run -> state 1 and phase_inc unchanged.
REQ-034 Reset mid-ramp: rst at wet_gain 3 in RAMP_UP -> next edge all REQ-028 values.
REQ-035 Continuous tick: STEP_SAMPLES=1 and sample_tick held 1 -> wet_gain steps every clock, 0->8 in 8 clocks.

Source files
------------

// File: rtl/robot_fx_sequencer.sv
// Wet/dry cross-fade sequencer for the robot-voice ring modulator: selects the
// carrier increment and ramps the wet mix up/down in sample-tick steps.
module robot_fx_sequencer #(
    parameter int unsigned STEP_SAMPLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic        fx_req,
    input  logic [1:0]  freq_sel,
    output logic        fx_enable,
    output logic [31:0] phase_inc,
    output logic [3:0]  wet_gain,
    output logic [1:0]  state,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_BYPASS    = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_ACTIVE    = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [15:0] STEP_LIM = STEP_SAMPLES[15:0];
    localparam logic [3:0]  GAIN_MAX = 4'd8;

    function automatic logic [31:0] inc_for(input logic [1:0] sel);
        case (sel)
            2'd0:    inc_for = 32'd26843545;
            2'd1:    inc_for = 32'd44739242;
            2'd2:    inc_for = 32'd71582788;
            default: inc_for = 32'd107374182;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  gain_q, gain_d;
    logic        en_q, en_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] inc_q, inc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic [15:0] cnt_inc;
    logic        step_hit;
    logic        keep;
    logic [3:0]  gain_nxt;

    assign cnt_inc  = cnt_q + 16'd1;
    assign step_hit = sample_tick && (cnt_inc == STEP_LIM);
    assign keep     = fx_req && (freq_sel == sel_q);

    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        en_d     = en_q;
        sel_d    = sel_q;
        inc_d    = inc_q;
        cnt_d    = cnt_q;
        gain_nxt = gain_q;

        case (state_q)
            S_BYPASS: begin
                gain_d = '0;
                if (fx_req) begin
                    sel_d   = freq_sel;
                    inc_d   = inc_for(freq_sel);
                    en_d    = 1'b1;
                    state_d = S_RAMP_UP;
                    cnt_d   = '0;
                end
            end
            S_RAMP_UP: begin
                if (!keep) begin
                    state_d = S_RAMP_DOWN;
                    cnt_d   = '0;
                end else if (step_hit) begin
                    cnt_d = '0;
                    if (gain_q >= GAIN_MAX - 4'd1) begin
                        gain_d  = GAIN_MAX;
                        state_d = S_ACTIVE;
                    end else begin
                        gain_d = gain_q + 4'd1;
                    end
                end else if (sample_tick) begin
                    cnt_d = cnt_inc;
                end
            end
            S_ACTIVE: begin
                if (!keep) begin
                    state_d = S_RAMP_DOWN;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (keep && gain_q != '0) begin
                    state_d = S_RAMP_UP;
                    cnt_d   = '0;
                end else begin
                    if (gain_q != '0 && step_hit) begin
                        cnt_d    = '0;
                        gain_nxt = gain_q - 4'd1;
                    end else if (gain_q != '0 && sample_tick) begin
                        cnt_d = cnt_inc;
                    end
                    gain_d = gain_nxt;
                    // Hitting zero resolves on the same edge: reload and climb, or drop out.
                    if (gain_nxt == '0) begin
                        cnt_d = '0;
                        if (fx_req) begin
                            sel_d   = freq_sel;
                            inc_d   = inc_for(freq_sel);
                            state_d = S_RAMP_UP;
                        end else begin
                            en_d    = 1'b0;
                            state_d = S_BYPASS;
                        end
                    end
                end
            end
        endcase

        busy_d = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BYPASS;
            gain_q  <= '0;
            en_q    <= 1'b0;
            sel_q   <= 2'd1;
            inc_q   <= 32'd44739242;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
            inc_q   <= inc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign fx_enable = en_q;
    assign phase_inc = inc_q;
    assign wet_gain  = gain_q;
    assign state     = state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_robot_fx_sequencer.sv
// Directed bench for robot_fx_sequencer: a rule-level model checked every cycle,
// plus hand-computed checkpoints and a STEP_SAMPLES=1 continuous-tick instance.
module tb_robot_fx_sequencer;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic        fx_req;
    logic [1:0]  freq_sel;
    logic        fx_enable;
    logic [31:0] phase_inc;
    logic [3:0]  wet_gain;
    logic [1:0]  state;
    logic        busy;

    logic        tick2;
    logic        fx_req2;
    logic [1:0]  freq_sel2;
    logic        fx_enable2;
    logic [31:0] phase_inc2;
    logic [3:0]  wet_gain2;
    logic [1:0]  state2;
    logic        busy2;

    int vectors = 0;
    int miscompares = 0;

    // model: mode 0 off, 1 fading in, 2 full, 3 fading out
    int m_mode, m_gain, m_part, m_sel;
    bit m_en;

    bit tick_on = 1'b0;
    int tick_ph = 0;
    int ticks_seen = 0;

    always #5 clk = ~clk;

    robot_fx_sequencer #(.STEP_SAMPLES(STEP)) u_dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .fx_req(fx_req),
        .freq_sel(freq_sel), .fx_enable(fx_enable), .phase_inc(phase_inc),
        .wet_gain(wet_gain), .state(state), .busy(busy)
    );

    robot_fx_sequencer #(.STEP_SAMPLES(1)) u_fast (
        .clk(clk), .rst(rst), .sample_tick(tick2), .fx_req(fx_req2),
        .freq_sel(freq_sel2), .fx_enable(fx_enable2), .phase_inc(phase_inc2),
        .wet_gain(wet_gain2), .state(state2), .busy(busy2)
    );

    function automatic longint unsigned inc_of(input int s);
        longint unsigned f;
        case (s)
            0:       f = 300;
            1:       f = 500;
            2:       f = 800;
            default: f = 1200;
        endcase
        return (f << 32) / 48000;
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit req, input int sel, input bit t);
        bit hold;
        hold = req && (sel == m_sel);
        if (r) begin
            m_mode = 0; m_gain = 0; m_en = 0; m_sel = 1; m_part = 0;
        end else if (m_mode == 0) begin
            if (req) begin m_sel = sel; m_en = 1; m_mode = 1; m_part = 0; end
        end else if (m_mode == 1) begin
            if (!hold) begin m_mode = 3; m_part = 0; end
            else if (t) begin
                m_part++;
                if (m_part == STEP) begin
                    m_part = 0;
                    if (m_gain < 8) m_gain++;
                    if (m_gain == 8) m_mode = 2;
                end
            end
        end else if (m_mode == 2) begin
            if (!hold) begin m_mode = 3; m_part = 0; end
        end else begin
            if (hold && m_gain > 0) begin m_mode = 1; m_part = 0; end
            else begin
                if (m_gain > 0 && t) begin
                    m_part++;
                    if (m_part == STEP) begin m_part = 0; m_gain--; end
                end
                if (m_gain == 0) begin
                    m_part = 0;
                    if (req) begin m_sel = sel; m_mode = 1; end
                    else begin m_mode = 0; m_en = 0; end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("state", state, m_mode);
        chk("wet_gain", wet_gain, m_gain);
        chk("fx_enable", fx_enable, m_en);
        chk("phase_inc", phase_inc, inc_of(m_sel));
        chk("busy", busy, (m_mode == 1 || m_mode == 3));
    endtask

    // One clock: present inputs, let the edge happen, then step the model and compare.
    task automatic cyc();
        bit r, rq, t;
        int s;
        sample_tick = tick_on && (tick_ph == 9);
        if (tick_on) tick_ph = (tick_ph + 1) % 10;
        if (sample_tick) ticks_seen++;
        r = rst; rq = fx_req; s = freq_sel; t = sample_tick;
        @(negedge clk);
        model_step(r, rq, s, t);
        compare_all();
    endtask

    task automatic run_ticks(input int n);
        int start;
        int guard;
        start = ticks_seen;
        guard = 0;
        while (ticks_seen - start < n && guard < 20 * n + 20) begin
            cyc();
            guard++;
        end
        chk("tick_budget", ticks_seen - start, n);
    endtask

    initial begin
        rst = 1'b1; sample_tick = 1'b0; fx_req = 1'b0; freq_sel = 2'd0;
        tick2 = 1'b0; fx_req2 = 1'b0; freq_sel2 = 2'd0;
        m_mode = 0; m_gain = 0; m_part = 0; m_sel = 1; m_en = 0;
        @(negedge clk);
        cyc(); cyc();
        chk("rst_state", state, 0);
        chk("rst_gain", wet_gain, 0);
        chk("rst_en", fx_enable, 0);
        chk("rst_phase", phase_inc, 44739242);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (3) cyc();

        // ramp up at 800 Hz
        fx_req = 1'b1; freq_sel = 2'd2;
        cyc();
        chk("up_en", fx_enable, 1);
        chk("up_phase", phase_inc, 71582788);
        chk("up_state", state, 1);
        tick_on = 1'b1; tick_ph = 0;
        run_ticks(4);
        chk("up_gain_t4", wet_gain, 1);
        run_ticks(28);
        chk("up_gain_t32", wet_gain, 8);
        chk("up_state_t32", state, 2);
        chk("up_busy_t32", busy, 0);
        repeat (40) cyc();
        chk("hold_gain", wet_gain, 8);

        // retune 800 -> 1200 Hz
        freq_sel = 2'd3;
        cyc();
        chk("rt_state", state, 3);
        run_ticks(28);
        chk("rt_gain_t28", wet_gain, 1);
        chk("rt_phase_old", phase_inc, 71582788);
        run_ticks(4);
        chk("rt_gain_t32", wet_gain, 0);
        chk("rt_phase_new", phase_inc, 107374182);
        chk("rt_state_up", state, 1);
        chk("rt_en", fx_enable, 1);
        run_ticks(32);
        chk("rt_gain_full", wet_gain, 8);
        chk("rt_state_act", state, 2);

        // fully release, then abort a ramp at gain 5
        fx_req = 1'b0;
        cyc();
        run_ticks(32);
        chk("rel_state", state, 0);
        chk("rel_en", fx_enable, 0);
        fx_req = 1'b1;
        cyc();
        run_ticks(20);
        chk("ab_gain5", wet_gain, 5);
        fx_req = 1'b0;
        cyc();
        chk("ab_state_dn", state, 3);
        run_ticks(16);
        chk("ab_gain1", wet_gain, 1);
        run_ticks(4);
        chk("ab_gain0", wet_gain, 0);
        chk("ab_state0", state, 0);
        chk("ab_en0", fx_enable, 0);

        // second run: reverse at gain 2 without reload
        fx_req = 1'b1;
        cyc();
        run_ticks(20);
        fx_req = 1'b0;
        cyc();
        run_ticks(12);
        chk("rev_gain2", wet_gain, 2);
        fx_req = 1'b1;
        cyc();
        chk("rev_state", state, 1);
        chk("rev_phase", phase_inc, 107374182);
        chk("rev_gain", wet_gain, 2);
        run_ticks(4);
        chk("rev_gain3", wet_gain, 3);

        // reset mid-ramp
        rst = 1'b1;
        cyc();
        chk("mr_state", state, 0);
        chk("mr_gain", wet_gain, 0);
        chk("mr_en", fx_enable, 0);
        chk("mr_phase", phase_inc, 44739242);
        chk("mr_busy", busy, 0);
        rst = 1'b0; fx_req = 1'b0;
        cyc();

        // continuous tick, one sample per step
        tick2 = 1'b1; fx_req2 = 1'b1;
        cyc();
        chk("ct_state", state2, 1);
        chk("ct_gain0", wet_gain2, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("ct_gain", wet_gain2, k);
        end
        chk("ct_state_act", state2, 2);
        chk("ct_busy", busy2, 0);
        chk("ct_phase", phase_inc2, 26843545);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
